// File: rtl/game_ctrl.sv
// game_ctrl: game state, level selection, per-frame timing, coin bookkeeping
// and score for NUM_COINS coins and NUM_LEVELS levels.
// All frame-rate actions are driven by a synchronised rising edge of frame_clk.
// Optional feature macro: GAME_CTRL_PAUSE_EN adds a PAUSE state toggled by key 'P'.
module game_ctrl #(
    parameter int         NUM_COINS    = 3,
    parameter int         NUM_LEVELS   = 2,
    parameter int         FRAME_W      = 12,
    parameter int         LEVEL_FRAMES = 3000,
    parameter int         SCORE_W      = 8,
    parameter logic [7:0] KEY_START    = 8'h28,
    parameter logic [7:0] KEY_RESTART  = 8'h15,
    parameter logic [7:0] KEY_LVL_BASE = 8'h1E
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_clk,
    input  logic [7:0]            keycode,
    input  logic [NUM_COINS-1:0]  coin_hit,
    input  logic                  stickman_dead,
    output logic [4:0]            status,
    output logic [NUM_LEVELS-1:0] level,
    output logic [FRAME_W-1:0]    frame_counter,
    output logic [NUM_COINS-1:0]  CoinStatus,
    output logic [SCORE_W-1:0]    score,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(NUM_COINS + 1);
    localparam int SUM_W = SCORE_W + CNT_W;
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(LEVEL_FRAMES - 1);
    localparam logic [SUM_W-1:0]   SCORE_MAX  = SUM_W'({SCORE_W{1'b1}});
`ifdef GAME_CTRL_PAUSE_EN
    localparam logic [7:0] KEY_PAUSE = 8'h13;
`endif

    typedef enum logic [2:0] {
        S_SELECT,
        S_WAIT,
        S_PLAY,
        S_WIN,
        S_LOSE
`ifdef GAME_CTRL_PAUSE_EN
        , S_PAUSE
`endif
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [NUM_LEVELS-1:0]   level_d;
    logic                    clr_counters;
    logic                    track;
    logic                    frame_sync_p0;
    logic                    frame_sync_p1;
    logic                    frame_sync_p2;
    logic [7:0]              key_prev;
    logic                    key_evt;
    logic                    lvl_hit;
    logic [NUM_LEVELS-1:0]   lvl_oh;

    // Number of set bits in a coin vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_COINS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Score addition that sticks at the all-ones value instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [CNT_W-1:0]   b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SCORE_MAX) begin
            return {SCORE_W{1'b1}};
        end
        return sum[SCORE_W-1:0];
    endfunction

    // One-hot status {selecting, waiting, playing, win, lose}; pause reads as waiting.
    function automatic logic [4:0] status_of(input state_t s);
        case (s)
            S_SELECT: return 5'b10000;
            S_WAIT:   return 5'b01000;
            S_PLAY:   return 5'b00100;
            S_WIN:    return 5'b00010;
            S_LOSE:   return 5'b00001;
`ifdef GAME_CTRL_PAUSE_EN
            S_PAUSE:  return 5'b01000;
`endif
            default:  return 5'b10000;
        endcase
    endfunction

    // A key event is a non-zero keycode that differs from the previous cycle's.
    assign key_evt = (keycode != 8'h00) && (keycode != key_prev);

    // frame_clk synchroniser (p0, p1) and edge detect (p2) producing a one-Clk frame_tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync_p0 <= 1'b0;
            frame_sync_p1 <= 1'b0;
            frame_sync_p2 <= 1'b0;
            frame_tick    <= 1'b0;
            key_prev      <= 8'h00;
        end else begin
            frame_sync_p0 <= frame_clk;
            frame_sync_p1 <= frame_sync_p0;
            frame_sync_p2 <= frame_sync_p1;
            frame_tick    <= frame_sync_p1 & ~frame_sync_p2;
            key_prev      <= keycode;
        end
    end

    // Level key decode: keycode KEY_LVL_BASE+k selects one-hot level bit k.
    always_comb begin
        lvl_hit = 1'b0;
        lvl_oh  = '0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            if (keycode == KEY_LVL_BASE + 8'(k)) begin
                lvl_hit   = 1'b1;
                lvl_oh    = '0;
                lvl_oh[k] = 1'b1;
            end
        end
    end

    // Next-state logic; death beats a winning tick, key transitions use events only.
    always_comb begin
        state_d      = state_q;
        level_d      = level;
        clr_counters = 1'b0;
        track        = 1'b0;
        case (state_q)
            S_SELECT: begin
                if (key_evt && lvl_hit) begin
                    level_d = lvl_oh;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (key_evt && keycode == KEY_START) begin
                    state_d      = S_PLAY;
                    clr_counters = 1'b1;
                end
            end
            S_PLAY: begin
                track = 1'b1;
                if (stickman_dead) begin
                    state_d = S_LOSE;
                end else if (frame_tick && frame_counter == LAST_FRAME) begin
                    state_d = S_WIN;
`ifdef GAME_CTRL_PAUSE_EN
                end else if (key_evt && keycode == KEY_PAUSE) begin
                    state_d = S_PAUSE;
`endif
                end
            end
            S_WIN, S_LOSE: begin
                if (key_evt && keycode == KEY_RESTART) begin
                    state_d      = S_SELECT;
                    clr_counters = 1'b1;
                end
            end
`ifdef GAME_CTRL_PAUSE_EN
            S_PAUSE: begin
                if (key_evt && keycode == KEY_PAUSE) begin
                    state_d = S_PLAY;
                end
            end
`endif
            default: state_d = S_SELECT;
        endcase
    end

    // State, registered one-hot status and selected level.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_SELECT;
            status  <= 5'b10000;
            level   <= NUM_LEVELS'(1);
        end else begin
            state_q <= state_d;
            status  <= status_of(state_d);
            level   <= level_d;
        end
    end

    // Frame counter, coin flags and score; only updated while actively playing.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_counter <= '0;
            CoinStatus    <= '0;
            score         <= '0;
        end else if (clr_counters) begin
            frame_counter <= '0;
            CoinStatus    <= '0;
            score         <= '0;
        end else if (track) begin
            if (frame_tick) begin
                frame_counter <= frame_counter + FRAME_W'(1);
            end
            CoinStatus <= CoinStatus | coin_hit;
            score      <= sat_add(score, popcount(coin_hit & ~CoinStatus));
        end
    end

endmodule
